ram_arbiter: RTL
================

# ram_arbiter

Shares the single-port, combinational-read, 1024-word RAM between the instruction-fetch port (IF, read-only) and the load/store port (D, read/write with byte enables). The block arbitrates per cycle and registers read data and acknowledgements. Partial-word stores are done as a two-cycle read-modify-write, because the RAM has no byte enables. It sits between the core's fetch/LSU stages and the RAM instance.

## Interface
- ADDR_W, 10, RAM word-address width; RAM depth is 2^ADDR_W words.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IF_REQ  in  1  fetch request; held with IF_ADDR until IF_GNT.
- IF_ADDR  in  32  fetch byte address.
- IF_GNT  out  1  fetch request accepted this cycle.
- IF_RVALID  out  1  one-cycle pulse; IF_RDATA is valid.
- IF_RDATA  out  32  registered fetch data.
- D_REQ  in  1  data request; held with the other D_* inputs until D_GNT.
- D_WE  in  1  1 = store, 0 = load.
- D_BE  in  4  store byte enables; bit i enables byte i (bits 8i+7:8i).
- D_ADDR  in  32  data byte address.
- D_WDATA  in  32  store data, in byte lanes matching D_BE.
- D_GNT  out  1  data request accepted this cycle.
- D_RVALID  out  1  one-cycle pulse: load data valid, or store complete.
- D_RDATA  out  32  registered load data; unchanged on store acks.
- RAM_ADDRESS  out  ADDR_W  to RAM ADDRESS.
- RAM_DATA_IN  out  32  to RAM DATA_IN.
- RAM_WRITE_ENABLE  out  1  to RAM WRITE_ENABLE.
- RAM_DATA_OUT  in  32  from RAM DATA_OUT (combinational read).

## Operation
- Word address = ADDR[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored: no misalignment trap, and out-of-range addresses wrap.
- FSM states: IDLE and RMW. Reset state is IDLE.
- IDLE arbitration:
  - At most one grant per cycle.
  - If only one port requests, that port is granted the same cycle.
  - If both request, grant the port that was not granted most recently (register LAST, 1 = D).
  - LAST updates on every grant. Reset value of LAST is IF, so D wins the first conflict.
- Granted fetch or load: RAM_ADDRESS = word address; RAM_DATA_OUT is captured into that port's RDATA at the edge.
- Granted store, D_BE = 4'b1111: RAM_WRITE_ENABLE = 1 in the grant cycle, with RAM_DATA_IN = D_WDATA.
- Granted store, D_BE = 4'b0000: no RAM write; still acknowledged.
- Granted store, any other D_BE:
  - Grant cycle: latch the word address, D_WDATA, D_BE and the current RAM_DATA_OUT (old word); go to RMW.
  - RMW cycle: RAM_ADDRESS = latched address, RAM_DATA_IN = merge (byte i = D_BE[i] ? new : old), RAM_WRITE_ENABLE = 1; return to IDLE.
  - No grants are issued in RMW; requests stay pending.
- IF_GNT, D_GNT and RAM_WRITE_ENABLE are combinational from state, requests and LAST. All three are forced to 0 while RESET is high.
- RAM_ADDRESS when idle with no request = IF word address; RAM_DATA_IN = D_WDATA. These are don't-care for the RAM but must be X-free.

## Timing
- Reset values: IF_RVALID = 0, D_RVALID = 0, IF_RDATA = 0, D_RDATA = 0, FSM = IDLE, LAST = IF.
- Read latency: grant at edge N; RVALID is high and RDATA holds the word during cycle N+1.
- Full-word and BE = 0 stores: D_RVALID pulses in cycle N+1.
- Partial stores: RAM write in cycle N+1; D_RVALID pulses in cycle N+2.
- Throughput: one access per cycle in IDLE, so back-to-back grants to the same or alternating ports are allowed. A partial store costs 2 cycles.
- A fetch granted in the cycle after a store to the same word reads the new data, because the RAM write completes at the grant edge.
- Reset asserted during RMW: the write is aborted (no WE), no ack is issued, and the FSM returns to IDLE.

## Test plan
- Reset, then IF_REQ with IF_ADDR = 0x10 and mem[4] = 0xDEADBEEF:
  - IF_GNT is 1 in the same cycle.
  - Next cycle: IF_RVALID = 1 and IF_RDATA = 0xDEADBEEF.
- D full store to 0x20 with 0x12345678 and BE = 1111, then a D load of 0x20:
  - Store ack 1 cycle after grant.
  - Load returns 0x12345678.
- mem[8] = 0xAABBCCDD; D store to 0x20 with 0x00001100 and BE = 0010:
  - RAM_WRITE_ENABLE is high only in the RMW cycle.
  - D_RVALID at grant + 2.
  - mem[8] becomes 0xAABB11DD.
- Both ports request continuously for 6 cycles after reset:
  - Grants go D, IF, D, IF, D, IF.
  - Exactly one GNT per cycle.
- Partial store granted, IF_REQ raised in the same cycle:
  - IF_GNT stays 0 during RMW.
  - IF is granted in the following IDLE cycle and sees the merged word if it reads the same address.
- Assert RESET during the RMW cycle of a BE = 0001 store:
  - Target word unchanged.
  - No D_RVALID pulse.
  - All outputs at their reset values.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: fetch port, load/store port and RAM-side signals of ram_arbiter.
// master = core + RAM side driving requests/read data, slave = the arbiter.
interface ram_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data_in;
    logic              ram_write_enable;
    logic [31:0]       ram_data_out;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_data_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_address, ram_data_in, ram_write_enable
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_data_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: per-cycle arbiter sharing one combinational-read RAM between fetch and load/store,
// with a two-cycle read-modify-write for partial-word stores.
module ram_arbiter #(
    parameter int ADDR_W = 10
) (
    input logic          CLK,
    input logic          RESET,
    ram_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RMW} state_t;

    state_t            state;
    logic              last;
    logic [ADDR_W-1:0] if_word, d_word, rmw_addr;
    logic [31:0]       rmw_old, rmw_new, merged, if_rdata, d_rdata;
    logic [3:0]        rmw_be;
    logic              idle, if_gnt, d_gnt, if_rvalid, d_rvalid, full, partial;
    logic              unused_addr_bits;

    assign if_word = bus.if_addr[ADDR_W+1:2];
    assign d_word  = bus.d_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2],
                                bus.d_addr[1:0], bus.d_addr[31:ADDR_W+2]};

    // last = 1 means D was granted most recently, so IF wins the next conflict
    assign idle    = state == IDLE && !RESET;
    assign d_gnt   = idle && bus.d_req && (!bus.if_req || !last);
    assign if_gnt  = idle && bus.if_req && (!bus.d_req || last);
    assign full    = bus.d_be == 4'hf;
    assign partial = bus.d_be != 4'h0 && !full;

    always_comb begin
        merged = rmw_old;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = rmw_be[i] ? rmw_new[8*i +: 8] : rmw_old[8*i +: 8];
    end

    assign bus.ram_write_enable = !RESET && (state == RMW || (d_gnt && bus.d_we && full));
    assign bus.ram_address      = state == RMW ? rmw_addr : d_gnt ? d_word : if_word;
    assign bus.ram_data_in      = state == RMW ? merged : bus.d_wdata;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_rdata   = d_rdata;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            last      <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            rmw_addr  <= '0;
            rmw_old   <= '0;
            rmw_new   <= '0;
            rmw_be    <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= state == RMW || (d_gnt && !(bus.d_we && partial));
            if (if_gnt) begin
                last     <= 1'b0;
                if_rdata <= bus.ram_data_out;
            end
            if (d_gnt) begin
                last <= 1'b1;
                if (!bus.d_we) d_rdata <= bus.ram_data_out;
            end
            if (d_gnt && bus.d_we && partial) begin
                state    <= RMW;
                rmw_addr <= d_word;
                rmw_old  <= bus.ram_data_out;
                rmw_new  <= bus.d_wdata;
                rmw_be   <= bus.d_be;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
